// File: rtl/up_adc_pn_sequencer.sv
// Register-bus master that walks each ADC channel through a PN-pattern link check:
// program pn_sel, clear sticky status, dwell, then read status into a pass vector.
module up_adc_pn_sequencer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter logic [13:0] CHAN_BASE    = 14'h0100,
  parameter logic [13:0] CHAN_STRIDE  = 14'h0010,
  parameter logic [3:0]  CNTRL3_OFS   = 4'h6,
  parameter logic [3:0]  STATUS_OFS   = 4'h1,
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                    up_clk,
  input  logic                    up_rstn,
  input  logic                    start,
  input  logic [3:0]              pn_sel,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CHANNELS-1:0] pass,
  output logic                    timeout,
  output logic                    up_wreq,
  output logic [13:0]             up_waddr,
  output logic [31:0]             up_wdata,
  input  logic                    up_wack,
  output logic                    up_rreq,
  output logic [13:0]             up_raddr,
  input  logic [31:0]             up_rdata,
  input  logic                    up_rack
);

  localparam int unsigned CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > ACK_TIMEOUT) ? DWELL_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CHANNELS - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_SEL, W_SEL_ACK, WR_CLR, W_CLR_ACK, DWELL, RD_STAT, W_RD_ACK, NEXT, DONE
  } state_t;

  state_t                  state, state_n;
  logic [CH_W-1:0]         ch, ch_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [3:0]              sel_q, sel_n;
  logic [NUM_CHANNELS-1:0] pass_n;
  logic                    timeout_n, busy_n, done_n, wreq_n, rreq_n;
  logic [13:0]             waddr_n, raddr_n;
  logic [31:0]             wdata_n;

  // Only the pn_err/pn_oos status bits decide pass; the rest of the word is don't-care.
  logic unused_rdata_c;
  assign unused_rdata_c = ^{up_rdata[31:3], up_rdata[0]};

  // Word address of a register inside a channel block, wrapping at 14 bits.
  function automatic logic [13:0] chan_addr(input logic [CH_W-1:0] c, input logic [3:0] ofs);
    return CHAN_BASE + 14'(c) * CHAN_STRIDE + 14'(ofs);
  endfunction

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state    <= IDLE;
      ch       <= '0;
      cnt      <= '0;
      sel_q    <= '0;
      pass     <= '0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      up_wreq  <= 1'b0;
      up_rreq  <= 1'b0;
      up_waddr <= '0;
      up_raddr <= '0;
      up_wdata <= '0;
    end else begin
      state    <= state_n;
      ch       <= ch_n;
      cnt      <= cnt_n;
      sel_q    <= sel_n;
      pass     <= pass_n;
      timeout  <= timeout_n;
      busy     <= busy_n;
      done     <= done_n;
      up_wreq  <= wreq_n;
      up_rreq  <= rreq_n;
      up_waddr <= waddr_n;
      up_raddr <= raddr_n;
      up_wdata <= wdata_n;
    end
  end

  // Next state plus next value of every registered output, keyed off the next state.
  always_comb begin
    state_n   = state;
    ch_n      = ch;
    cnt_n     = cnt;
    sel_n     = sel_q;
    pass_n    = pass;
    timeout_n = timeout;

    unique case (state)
      IDLE: begin
        if (start) begin
          sel_n     = pn_sel;
          ch_n      = '0;
          pass_n    = '0;
          timeout_n = 1'b0;
          state_n   = WR_SEL;
        end
      end
      WR_SEL: begin
        cnt_n   = '0;
        state_n = W_SEL_ACK;
      end
      W_SEL_ACK: begin
        if (up_wack) begin
          state_n = WR_CLR;
        end else if (cnt == ACK_LAST) begin
          timeout_n  = 1'b1;
          pass_n[ch] = 1'b0;
          state_n    = NEXT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WR_CLR: begin
        cnt_n   = '0;
        state_n = W_CLR_ACK;
      end
      W_CLR_ACK: begin
        if (up_wack) begin
          cnt_n   = DWELL_LOAD;
          state_n = DWELL;
        end else if (cnt == ACK_LAST) begin
          timeout_n  = 1'b1;
          pass_n[ch] = 1'b0;
          state_n    = NEXT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DWELL: begin
        if (cnt == '0) begin
          state_n = RD_STAT;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RD_STAT: begin
        cnt_n   = '0;
        state_n = W_RD_ACK;
      end
      W_RD_ACK: begin
        if (up_rack) begin
          pass_n[ch] = ~up_rdata[2] & ~up_rdata[1];
          state_n    = NEXT;
        end else if (cnt == ACK_LAST) begin
          timeout_n  = 1'b1;
          pass_n[ch] = 1'b0;
          state_n    = NEXT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      NEXT: begin
        if (ch == LAST_CH) begin
          state_n = DONE;
        end else begin
          ch_n    = ch + CH_W'(1);
          state_n = WR_SEL;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n != IDLE) && (state_n != DONE);
    done_n  = (state_n == DONE);
    wreq_n  = (state_n == WR_SEL) || (state_n == WR_CLR);
    rreq_n  = (state_n == RD_STAT);
    waddr_n = up_waddr;
    wdata_n = up_wdata;
    raddr_n = up_raddr;
    if (state_n == WR_SEL) begin
      waddr_n = chan_addr(ch_n, CNTRL3_OFS);
      wdata_n = {12'h000, sel_n, 16'h0000};
    end
    if (state_n == WR_CLR) begin
      waddr_n = chan_addr(ch_n, STATUS_OFS);
      wdata_n = 32'h0000_0007;
    end
    if (state_n == RD_STAT) begin
      raddr_n = chan_addr(ch_n, STATUS_OFS);
    end
  end

endmodule

// File: tb/tb_up_adc_pn_sequencer.sv
// Bench for up_adc_pn_sequencer: randomized-latency bus responder, transaction log,
// and a channel-loop reference model of the expected register traffic and results.
module tb_up_adc_pn_sequencer;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DWELL = 1024;
  localparam int unsigned ACKTO = 255;
  localparam int          LIMIT = 20000;

  logic            up_clk = 1'b0;
  logic            up_rstn = 1'b1;
  logic            start = 1'b0;
  logic [3:0]      pn_sel = 4'h0;
  logic            busy, done, timeout;
  logic [NCH-1:0]  pass;
  logic            up_wreq, up_rreq;
  logic [13:0]     up_waddr, up_raddr;
  logic [31:0]     up_wdata;
  logic            up_wack = 1'b0;
  logic            up_rack = 1'b0;
  logic [31:0]     up_rdata = 32'h0;

  up_adc_pn_sequencer #(
    .NUM_CHANNELS(NCH), .CHAN_BASE(14'h0100), .CHAN_STRIDE(14'h0010),
    .CNTRL3_OFS(4'h6), .STATUS_OFS(4'h1), .DWELL_CYCLES(DWELL), .ACK_TIMEOUT(ACKTO)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn), .start(start), .pn_sel(pn_sel),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  always #5 up_clk = ~up_clk;

  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        got_q[$];
  int          got_cyc[$];
  txn_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  // Main-process controls for the responder
  logic [31:0] stat [NCH];
  bit          drop_en = 1'b0;
  logic [13:0] drop_addr = 14'h0;
  bit          spur_en = 1'b0;
  int          spur_req = 0;

  // Responder-owned observations
  int          spur_done = 0;
  int          clr_ack_cyc = -100000;
  int          dwell_meas = 0;
  int          done_cnt = 0;
  int          overlap = 0;
  bit          pend = 1'b0;
  int          pend_lat = 0;
  bit          pend_wr = 1'b0;
  logic [13:0] pend_addr = 14'h0;

  always @(posedge up_clk) cyc <= cyc + 1;

  always @(negedge up_clk) begin
    if (up_wreq && up_rreq) overlap++;
    if (done) done_cnt++;
  end

  // Bus responder: acks each request 1..3 cycles later unless it is the dropped address.
  always begin
    int idx;
    @(posedge up_clk);
    #1;
    up_wack = 1'b0;
    up_rack = 1'b0;
    if (!up_rstn) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_lat <= 1) begin
          pend = 1'b0;
          if (pend_wr) begin
            up_wack = 1'b1;
            if (pend_addr[3:0] == 4'h1) clr_ack_cyc = cyc;
          end else begin
            idx = (int'(pend_addr) - 256) / 16;
            up_rdata = stat[idx];
            up_rack = 1'b1;
          end
        end else begin
          pend_lat--;
        end
      end else if (spur_req != spur_done) begin
        up_wack = 1'b1;
        up_rack = 1'b1;
        spur_done++;
      end else if (spur_en && cyc == clr_ack_cyc + 100) begin
        up_wack = 1'b1;
        up_rack = 1'b1;
      end
      if (up_wreq || up_rreq) begin
        got_q.push_back(txn_t'{wr: up_wreq, addr: (up_wreq ? up_waddr : up_raddr),
                               data: (up_wreq ? up_wdata : 32'h0)});
        got_cyc.push_back(cyc);
        if (!up_wreq) dwell_meas = cyc - clr_ack_cyc;
        if (!(drop_en && up_wreq && up_waddr == drop_addr)) begin
          pend      = 1'b1;
          pend_lat  = int'($urandom_range(1, 3));
          pend_wr   = up_wreq;
          pend_addr = up_wreq ? up_waddr : up_raddr;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: per channel, sel write, status clear, status read; a dropped sel write ends the channel.
  task automatic build_exp(input logic [3:0] sel, input int drop_ch, output logic [NCH-1:0] pexp);
    exp_q.delete();
    pexp = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      logic [13:0] blk;
      blk = 14'(256 + 16 * c);
      exp_q.push_back(txn_t'{wr: 1'b1, addr: blk + 14'd6, data: {12'h0, sel, 16'h0}});
      if (c != drop_ch) begin
        exp_q.push_back(txn_t'{wr: 1'b1, addr: blk + 14'd1, data: 32'h7});
        exp_q.push_back(txn_t'{wr: 1'b0, addr: blk + 14'd1, data: 32'h0});
        pexp[c] = (stat[c][2:1] == 2'b00);
      end
    end
  endtask

  task automatic run_seq(input logic [3:0] sel, input int drop_ch, input bit poke_busy);
    logic [NCH-1:0] pexp;
    int base, dbase, n, ntx;
    drop_en   = (drop_ch >= 0);
    drop_addr = 14'(256 + 16 * drop_ch + 6);
    build_exp(sel, drop_ch, pexp);
    base  = got_q.size();
    dbase = done_cnt;
    @(negedge up_clk);
    pn_sel = sel;
    start  = 1'b1;
    @(negedge up_clk);
    start = 1'b0;
    check("busy_on_start", busy, 1);
    check("pass_clr_on_start", pass, 0);
    check("timeout_clr_on_start", timeout, 0);
    if (poke_busy) begin
      repeat (20) @(negedge up_clk);
      pn_sel = sel ^ 4'hA;
      start  = 1'b1;
      @(negedge up_clk);
      start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      @(negedge up_clk);
      n++;
    end
    check("done_within_budget", (n < LIMIT), 1);
    check("busy_low_in_done", busy, 0);
    @(negedge up_clk);
    check("done_one_cycle", done, 0);
    check("done_pulse_count", done_cnt - dbase, 1);
    check("pass", pass, pexp);
    check("timeout", timeout, (drop_ch >= 0));
    ntx = got_q.size() - base;
    check("txn_count", ntx, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ntx; i++)
      check($sformatf("txn%0d", i), got_q[base + i], exp_q[i]);
    check("dwell_ack_to_rreq", dwell_meas, DWELL + 1);
    if (drop_ch >= 0 && ntx > 3 * drop_ch + 1)
      check("ack_timeout_gap", got_cyc[base + 3 * drop_ch + 1] - got_cyc[base + 3 * drop_ch],
            ACKTO + 2);
    drop_en = 1'b0;
  endtask

  initial begin
    int base, dbase, n;
    for (int c = 0; c < int'(NCH); c++) stat[c] = 32'h0;

    // Reset values
    #1 up_rstn = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_wreq", up_wreq, 0);
    check("rst_rreq", up_rreq, 0);
    check("rst_waddr", up_waddr, 0);
    check("rst_raddr", up_raddr, 0);
    check("rst_wdata", up_wdata, 0);
    repeat (3) @(negedge up_clk);
    up_rstn = 1'b1;
    repeat (2) @(negedge up_clk);

    // Unsolicited acks while idle
    base  = got_q.size();
    dbase = done_cnt;
    for (int k = 0; k < 3; k++) begin
      spur_req++;
      repeat (3) @(negedge up_clk);
    end
    check("idle_spur_no_txn", got_q.size() - base, 0);
    check("idle_spur_busy", busy, 0);
    check("idle_spur_no_done", done_cnt - dbase, 0);

    // Clean run, spurious acks in dwell, restart attempt while busy
    spur_en = 1'b1;
    run_seq(4'h5, -1, 1'b1);
    spur_en = 1'b0;

    // Mixed status results
    stat[0] = 32'h0; stat[1] = 32'h4; stat[2] = 32'h2; stat[3] = 32'h1;
    run_seq(4'h9, -1, 1'b0);

    // Channel 2 control write never acked
    for (int c = 0; c < int'(NCH); c++) stat[c] = 32'h0;
    run_seq(4'h3, 2, 1'b0);

    // Reset during channel 1 dwell
    base = got_q.size();
    @(negedge up_clk);
    pn_sel = 4'hC;
    start  = 1'b1;
    @(negedge up_clk);
    start = 1'b0;
    n = 0;
    while (got_q.size() < base + 5 && n < LIMIT) begin
      @(negedge up_clk);
      n++;
    end
    check("reach_ch1_dwell", (n < LIMIT), 1);
    repeat (50) @(negedge up_clk);
    check("pre_rst_pass_ch0", pass[0], 1);
    #2 up_rstn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_wreq", up_wreq, 0);
    check("mid_rst_rreq", up_rreq, 0);
    check("mid_rst_waddr", up_waddr, 0);
    check("mid_rst_raddr", up_raddr, 0);
    check("mid_rst_wdata", up_wdata, 0);
    repeat (3) @(negedge up_clk);
    up_rstn = 1'b1;
    repeat (2) @(negedge up_clk);
    run_seq(4'hC, -1, 1'b0);

    // Randomized status words and pattern codes
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < int'(NCH); c++) stat[c] = $urandom;
      run_seq(4'($urandom), -1, 1'b0);
    end

    check("no_req_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/up_adc_pn_sequencer.md
Name: up_adc_pn_sequencer

Overview:
- Register-bus master that runs an automated per-channel PN-sequence link check on an ADC JESD204 core through the core's up_* register interface.
- On start, for each channel in turn: program PN select, clear sticky status, dwell, read PN status. Produces a per-channel pass vector plus done/timeout flags.
- Sits in the up_clk domain beside the host bus; an external mux grants it the bus while busy is high.

Parameters:
NUM_CHANNELS, 4, channels checked, 1..16
CHAN_BASE, 14'h0100, word address of channel 0 register block
CHAN_STRIDE, 14'h0010, word-address step between channel blocks
CNTRL3_OFS, 4'h6, channel control-3 register offset (pn_sel at bits 19:16)
STATUS_OFS, 4'h1, channel status register offset (bit2 pn_err, bit1 pn_oos, bit0 or; write-1-to-clear)
DWELL_CYCLES, 1024, up_clk cycles between status clear and status read, >=1
ACK_TIMEOUT, 255, max cycles waiting for wack/rack, >=1

Ports:
up_clk  input  1  register-domain clock
up_rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begins sequence; ignored while busy
pn_sel  input  4  PN pattern code written to every channel, sampled on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at sequence end
pass  output  NUM_CHANNELS  bit i = channel i had pn_err=0 and pn_oos=0
timeout  output  1  sticky; set when any ack wait expires, cleared on next accepted start
up_wreq  output  1  one-cycle write request
up_waddr  output  14  write word address
up_wdata  output  32  write data
up_wack  input  1  write acknowledge
up_rreq  output  1  one-cycle read request
up_raddr  output  14  read word address
up_rdata  input  32  read data, valid with up_rack
up_rack  input  1  read acknowledge

Behaviour:
- Reset (async, up_rstn=0): state IDLE, busy=0, done=0, pass=0, timeout=0, up_wreq=0, up_rreq=0, up_waddr=0, up_raddr=0, up_wdata=0, channel index=0. All outputs registered.
- States: IDLE, WR_SEL, W_SEL_ACK, WR_CLR, W_CLR_ACK, DWELL, RD_STAT, W_RD_ACK, NEXT, DONE.
- IDLE: start=1 -> latch pn_sel, ch=0, pass=0, timeout=0, busy=1, go WR_SEL next cycle.
- WR_SEL: up_wreq=1 for exactly one cycle, up_waddr=CHAN_BASE+ch*CHAN_STRIDE+CNTRL3_OFS, up_wdata={12'h0,pn_sel,16'h0}; -> W_SEL_ACK.
- WR_CLR: same, address offset STATUS_OFS, data 32'h7; -> W_CLR_ACK.
- W_*_ACK: wait up_wack (or up_rack for W_RD_ACK); timeout counter reset on entry, increments per cycle; ack on cycle where count<ACK_TIMEOUT advances; count reaches ACK_TIMEOUT without ack -> timeout=1, pass[ch]=0, go NEXT (channel skipped). Ack arriving same cycle as expiry counts as ack.
- W_CLR_ACK ack -> DWELL: counter loads DWELL_CYCLES-1, decrements, at 0 -> RD_STAT. Dwell length exactly DWELL_CYCLES cycles.
- RD_STAT: up_rreq one cycle, up_raddr=channel STATUS address; -> W_RD_ACK. On rack: pass[ch] = ~up_rdata[2] & ~up_rdata[1]; bit0 ignored.
- NEXT: ch==NUM_CHANNELS-1 -> DONE, else ch+1 -> WR_SEL.
- DONE: done=1 one cycle, busy=0, -> IDLE. pass/timeout hold until next accepted start.
- Requests never overlap: at most one outstanding transaction; wreq and rreq never high together.
- Spurious wack/rack outside matching wait state ignored.
- start while busy ignored; start in DONE cycle ignored (accepted from IDLE only).
- Minimum sequence per channel (zero-latency-after-request acks, ack 1 cycle after req): WR_SEL 1 + ack wait 1 + WR_CLR 1 + ack 1 + DWELL + RD 1 + ack 1 + NEXT 1.
- Address arithmetic modulo 2^14; ch width = clog2(NUM_CHANNELS), min 1.
- Reset mid-sequence: immediate return to reset values; any in-flight request dropped.

Test Plan:
- NUM_CHANNELS=4, responder acks 2 cycles after each req, status reads return 0, pn_sel=4'h5 -> 12 transactions in order ch0..3 (wdata 32'h0005_0000 to 0x106/0x116/0x126/0x136, 32'h7 to 0x101..0x131), reads at 0x101..0x131, pass=4'hF, timeout=0, one done pulse.
- Status read ch1 returns 32'h4, ch2 returns 32'h2, ch3 returns 32'h1 -> pass=4'b1001.
- Responder never acks ch2 control-3 write, ACK_TIMEOUT=255 -> after 255 cycles timeout=1, pass[2]=0, ch2 gets no further transactions, ch3 runs, done pulses.
- DWELL_CYCLES=1024: measure cycles from W_CLR_ACK ack to status rreq -> exactly 1024 (+1 state cycle as defined); start pulsed while busy -> no restart, pn_sel change not applied.
- up_rstn dropped during DWELL of ch1 -> all outputs zero same cycle (async); after release, start -> full sequence from ch0, timeout/pass cleared.
- Unsolicited up_wack/up_rack pulses in IDLE and DWELL -> no state change, no transaction.
